// File: rtl/seg_display_decoder_if.sv
// HEX display bus into the decoder and the decoded result coming back out.
interface seg_display_decoder_if #(
  parameter int unsigned P_DIGITS = 6
);
  logic [8*P_DIGITS-1:0] hex_in;
  logic [4*P_DIGITS-1:0] value;
  logic [P_DIGITS-1:0]   digit_valid;
  logic [P_DIGITS-1:0]   dp;
  logic                  err;
  logic                  update;

  // master drives the display patterns, slave is the decoder
  modport master (output hex_in, input value, digit_valid, dp, err, update);
  modport slave  (input hex_in, output value, digit_valid, dp, err, update);
endinterface

// File: rtl/seg_display_decoder.sv
// Recovers hex nibbles from active-low seven-segment patterns once the bus has
// settled, scanning one digit per cycle and committing the whole frame at once.
module seg_display_decoder #(
  parameter int unsigned P_DIGITS        = 6,
  parameter int unsigned P_STABLE_CYCLES = 4
) (
  input  logic                 clk1_i,
  input  logic                 rst_i,
  seg_display_decoder_if.slave bus
);
  localparam int unsigned IDX_W = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(P_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(P_STABLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  logic [P_DIGITS-1:0][7:0] hex_c;
  logic [P_DIGITS-1:0][7:0] sample_q;
  logic                     changed_c;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     pending_q, pending_d;
  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     scan_c, commit_c;

  logic [7:0]               cur_byte_c;
  logic [4:0]               cur_lookup_c;
  logic                     cur_bad_c;

  logic [P_DIGITS-1:0][3:0] val_s_q, val_s_d;
  logic [P_DIGITS-1:0]      valid_s_q, valid_s_d;
  logic [P_DIGITS-1:0]      dp_s_q, dp_s_d;
  logic                     err_s_q, err_s_d;

  logic [P_DIGITS-1:0][3:0] value_q;
  logic [P_DIGITS-1:0]      valid_q;
  logic [P_DIGITS-1:0]      dp_q;
  logic                     err_q;
  logic                     update_q;

  // Returns {legal, nibble}; blank and illegal patterns both come back not-legal.
  function automatic logic [4:0] glyph_lookup(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h18:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h27:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign hex_c     = bus.hex_in;
  assign changed_c = (hex_c != sample_q);

  // Stability tracking; a change at the commit edge re-arms PENDING.
  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    if (changed_c) begin
      count_d   = CNT_W'(1);
      pending_d = 1'b1;
    end else begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
      if (commit_c) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pending_d && (count_d == CNT_MAX)) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (changed_c) begin
          state_d = S_IDLE;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scan_c   = 1'b0;
    commit_c = 1'b0;
    idx_d    = '0;
    case (state_q)
      S_SCAN: begin
        scan_c = !changed_c;
        idx_d  = idx_q + IDX_W'(1);
      end
      S_COMMIT: commit_c = 1'b1;
      default: ;
    endcase
  end

  assign cur_byte_c   = sample_q[idx_q];
  assign cur_lookup_c = glyph_lookup(cur_byte_c[6:0]);
  assign cur_bad_c    = !cur_lookup_c[4] && (cur_byte_c[6:0] != 7'h7F);

  // Scratch decode; the error flag restarts at digit 0 of every scan.
  always_comb begin
    val_s_d   = val_s_q;
    valid_s_d = valid_s_q;
    dp_s_d    = dp_s_q;
    err_s_d   = err_s_q;
    if (scan_c) begin
      val_s_d[idx_q]   = cur_lookup_c[4] ? cur_lookup_c[3:0] : 4'h0;
      valid_s_d[idx_q] = cur_lookup_c[4];
      dp_s_d[idx_q]    = !cur_byte_c[7];
      err_s_d          = ((idx_q == '0) ? 1'b0 : err_s_q) | cur_bad_c;
    end
  end

  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      sample_q  <= '1;
      count_q   <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      val_s_q   <= '0;
      valid_s_q <= '0;
      dp_s_q    <= '0;
      err_s_q   <= 1'b0;
      value_q   <= '0;
      valid_q   <= '0;
      dp_q      <= '0;
      err_q     <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      sample_q  <= hex_c;
      count_q   <= count_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      val_s_q   <= val_s_d;
      valid_s_q <= valid_s_d;
      dp_s_q    <= dp_s_d;
      err_s_q   <= err_s_d;
      update_q  <= commit_c;
      if (commit_c) begin
        value_q <= val_s_q;
        valid_q <= valid_s_q;
        dp_q    <= dp_s_q;
        err_q   <= err_s_q;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.dp          = dp_q;
  assign bus.err         = err_q;
  assign bus.update      = update_q;
endmodule

// File: tb/tb_seg_display_decoder.sv
// Bench for seg_display_decoder: directed scenarios plus random frames, all
// compared against a run-length reference model of the settle/scan/commit rules.
module tb_seg_display_decoder;
  localparam int unsigned ND  = 6;
  localparam int unsigned NS  = 4;
  localparam int unsigned LAT = NS + ND;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  seg_display_decoder_if #(.P_DIGITS(ND)) bus ();

  seg_display_decoder #(.P_DIGITS(ND), .P_STABLE_CYCLES(NS)) dut (
    .clk1_i (clk),
    .rst_i  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [8*ND-1:0] f, output logic [4*ND-1:0] v,
                                     output logic [ND-1:0] ok, output logic [ND-1:0] dpo,
                                     output logic e);
    logic [6:0] seg;
    v = '0; ok = '0; dpo = '0; e = 1'b0;
    for (int d = 0; d < int'(ND); d++) begin
      seg    = f[8*d +: 7];
      dpo[d] = ~f[8*d+7];
      for (int k = 0; k < 16; k++) begin
        if (glyph_tab[k] == seg) begin
          v[4*d +: 4] = 4'(k);
          ok[d]       = 1'b1;
        end
      end
      if (!ok[d] && seg != 7'h7F) e = 1'b1;
    end
  endfunction

  // Reference model: a frame commits on the edge after a change-started run of
  // identical samples reaches NS+ND edges.
  logic [8*ND-1:0] m_held;
  int              m_run;
  bit              m_armed;
  logic [4*ND-1:0] e_value;
  logic [ND-1:0]   e_valid, e_dp;
  logic            e_err, e_upd;

  always @(posedge clk) begin : model
    logic [4*ND-1:0] v;
    logic [ND-1:0]   ok, dpo;
    logic            e;
    if (rst) begin
      m_held <= '1; m_run <= 0; m_armed <= 1'b0;
      e_value <= '0; e_valid <= '0; e_dp <= '0; e_err <= 1'b0; e_upd <= 1'b0;
    end else begin
      e_upd <= m_armed && (m_run == int'(LAT));
      if (m_armed && (m_run == int'(LAT))) begin
        ref_decode(m_held, v, ok, dpo, e);
        e_value <= v; e_valid <= ok; e_dp <= dpo; e_err <= e;
      end
      if (bus.hex_in != m_held) begin
        m_held <= bus.hex_in; m_run <= 1; m_armed <= 1'b1;
      end else if (m_run < 100000) begin
        m_run <= m_run + 1;
      end
    end
  end

  function automatic logic [8*ND-1:0] rand_frame(input bit allow_bad);
    logic [8*ND-1:0] f;
    logic [6:0]      seg;
    int unsigned     r;
    for (int d = 0; d < int'(ND); d++) begin
      r = $urandom_range(0, 99);
      if (!allow_bad || r < 70) seg = glyph_tab[$urandom_range(0, 15)];
      else if (r < 85)          seg = 7'h7F;
      else                      seg = 7'($urandom);
      f[8*d +: 8] = {1'($urandom), seg};
    end
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.hex_in = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.value, bus.digit_valid, bus.dp, bus.err, bus.update} !== '0) begin
        $display("FAIL reset_idle edge %0d: value=%h valid=%b dp=%b err=%b upd=%b, want all 0",
                 c, bus.value, bus.digit_valid, bus.dp, bus.err, bus.update);
        errors++;
      end
    end
  endtask

  task automatic test_sweep();
    int upd, upd_at;
    for (int i = 0; i < 16; i++) begin
      upd = 0; upd_at = 0;
      @(negedge clk);
      bus.hex_in = '1;
      bus.hex_in[7:0] = {1'b1, glyph_tab[i]};
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        checks++;
        if (bus.update !== e_upd) begin
          $display("FAIL sweep_upd glyph %0d edge %0d: got %b want %b", i, c, bus.update, e_upd);
          errors++;
        end
        if (bus.update === 1'b1) begin upd++; upd_at = c; end
      end
      checks++;
      if (upd != 1 || upd_at != 11) begin
        $display("FAIL sweep_latency glyph %0d: got %0d pulses at edge %0d, want 1 at edge 11",
                 i, upd, upd_at);
        errors++;
      end
      checks++;
      if (bus.value !== 24'(i) || bus.digit_valid !== 6'b000001 || bus.dp !== 6'b0 ||
          bus.err !== 1'b0) begin
        $display("FAIL sweep_value glyph %0d: got value=%h valid=%b dp=%b err=%b, want %h 000001 0 0",
                 i, bus.value, bus.digit_valid, bus.dp, bus.err, 24'(i));
        errors++;
      end
    end
  endtask

  task automatic test_full_frame();
    @(negedge clk);
    bus.hex_in = {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82};
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.update !== e_upd) begin
        $display("FAIL frame_upd edge %0d: got %b want %b", c, bus.update, e_upd);
        errors++;
      end
    end
    checks++;
    if (bus.value !== 24'h123456 || bus.digit_valid !== 6'h3F || bus.dp !== 6'b000100 ||
        bus.err !== 1'b0) begin
      $display("FAIL frame_value: got value=%h valid=%h dp=%b err=%b, want 123456 3f 000100 0",
               bus.value, bus.digit_valid, bus.dp, bus.err);
      errors++;
    end
  endtask

  task automatic test_glitch();
    int upd, upd_at;
    upd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.hex_in = '1;
      bus.hex_in[7:0] = (k % 2 == 0) ? 8'hF9 : 8'hC0;
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.update === 1'b1) upd++;
      end
    end
    checks++;
    if (upd != 0) begin
      $display("FAIL glitch_quiet: got %0d pulses while toggling, want 0", upd);
      errors++;
    end
    upd = 0; upd_at = 0;
    @(negedge clk);
    bus.hex_in[7:0] = 8'hF9;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.update === 1'b1) begin upd++; upd_at = c; end
    end
    checks++;
    if (upd != 1 || upd_at != 11 || bus.value[3:0] !== 4'h1) begin
      $display("FAIL glitch_settle: got %0d pulses at edge %0d value=%h, want 1 at 11 value 1",
               upd, upd_at, bus.value[3:0]);
      errors++;
    end
  endtask

  task automatic test_abort();
    logic [8*ND-1:0] fa, fb;
    logic [4*ND-1:0] v;
    logic [ND-1:0]   ok, dpo;
    logic            e;
    logic [3:0]      n0;
    int              upd, upd_at;
    for (int t = 0; t < 3; t++) begin
      do fa = rand_frame(1'b0); while (fa == bus.hex_in);
      n0 = 4'($urandom_range(0, 15));
      fa[6:0] = glyph_tab[n0];
      fb = fa;
      fb[6:0] = glyph_tab[4'(n0 + 4'd1)];
      upd = 0; upd_at = 0;
      @(negedge clk);
      bus.hex_in = fa;
      repeat (5) begin
        @(posedge clk); #1;
        if (bus.update === 1'b1) upd++;
      end
      @(negedge clk);
      bus.hex_in = fb;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (bus.update === 1'b1) begin upd++; upd_at = c; end
      end
      ref_decode(fb, v, ok, dpo, e);
      checks++;
      if (upd != 1 || upd_at != 11) begin
        $display("FAIL abort_pulses run %0d: got %0d pulses last at edge %0d, want 1 at 11",
                 t, upd, upd_at);
        errors++;
      end
      checks++;
      if (bus.value !== v || bus.digit_valid !== ok || bus.dp !== dpo || bus.err !== e) begin
        $display("FAIL abort_value run %0d: got %h %b %b %b want %h %b %b %b", t,
                 bus.value, bus.digit_valid, bus.dp, bus.err, v, ok, dpo, e);
        errors++;
      end
    end
  endtask

  task automatic test_illegal_reset();
    logic [8*ND-1:0] f;
    logic [4*ND-1:0] want;
    logic [3:0]      n;
    int              upd, upd_at;
    want = '0;
    for (int d = 0; d < int'(ND); d++) begin
      n = 4'($urandom_range(0, 15));
      f[8*d +: 8] = {1'b1, glyph_tab[n]};
      want[4*d +: 4] = n;
    end
    f[31:24] = 8'h55;
    want[15:12] = 4'h0;
    @(negedge clk);
    bus.hex_in = f;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b1 || bus.digit_valid !== 6'b110111 || bus.value !== want ||
        bus.dp !== 6'b001000) begin
      $display("FAIL illegal_digit: got value=%h valid=%b dp=%b err=%b, want %h 110111 001000 1",
               bus.value, bus.digit_valid, bus.dp, bus.err, want);
      errors++;
    end
    @(negedge clk);
    bus.hex_in = rand_frame(1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.value, bus.digit_valid, bus.dp, bus.err, bus.update} !== '0) begin
      $display("FAIL reset_midscan: got value=%h valid=%b dp=%b err=%b upd=%b, want all 0",
               bus.value, bus.digit_valid, bus.dp, bus.err, bus.update);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    upd = 0; upd_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.update !== e_upd) begin
        $display("FAIL post_reset_upd edge %0d: got %b want %b", c, bus.update, e_upd);
        errors++;
      end
      if (bus.update === 1'b1) begin upd++; upd_at = c; end
    end
    checks++;
    if (upd != 1 || upd_at != 11) begin
      $display("FAIL post_reset_commit: got %0d pulses at edge %0d, want 1 at 11", upd, upd_at);
      errors++;
    end
  endtask

  task automatic test_random();
    int hold;
    for (int t = 0; t < 40; t++) begin
      hold = $urandom_range(1, 14);
      @(negedge clk);
      if ($urandom_range(0, 5) != 0) bus.hex_in = rand_frame(1'b1);
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if (bus.update !== e_upd ||
            {bus.value, bus.digit_valid, bus.dp, bus.err} !== {e_value, e_valid, e_dp, e_err}) begin
          $display("FAIL random frame %0d: got upd=%b %h %b %b %b want upd=%b %h %b %b %b", t,
                   bus.update, bus.value, bus.digit_valid, bus.dp, bus.err,
                   e_upd, e_value, e_valid, e_dp, e_err);
          errors++;
        end
      end
    end
  endtask

  initial begin
    bus.hex_in = '1;
    test_reset();
    test_sweep();
    test_full_frame();
    test_glitch();
    test_abort();
    test_illegal_reset();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
